// File: rtl/fmap_rd_pkg.sv
// fmap_rd_pkg: shared definitions for the feature-map read controller.
// Holds the controller state encoding, the mode-to-size table and the
// largest legal mode value.
package fmap_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_GAP    = 3'd2,
        ST_STREAM = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5
    } fmap_state_e;

    localparam logic [2:0] MAX_MODE = 3'd4;

    localparam logic [5:0] SIZE_MODE0 = 6'd32;
    localparam logic [5:0] SIZE_MODE1 = 6'd28;
    localparam logic [5:0] SIZE_MODE2 = 6'd14;
    localparam logic [5:0] SIZE_MODE3 = 6'd10;
    localparam logic [5:0] SIZE_MODE4 = 6'd5;

    // Square edge length (in pixels) of the feature map selected by a mode.
    function automatic logic [5:0] mode_to_size(input logic [2:0] m);
        logic [5:0] s;
        case (m)
            3'd0:    s = SIZE_MODE0;
            3'd1:    s = SIZE_MODE1;
            3'd2:    s = SIZE_MODE2;
            3'd3:    s = SIZE_MODE3;
            3'd4:    s = SIZE_MODE4;
            default: s = SIZE_MODE0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// rd_valid_pipe: fixed-depth shift register carrying the {weight, pixel}
// valid flags alongside the RAM read latency. A synchronous clear drops
// everything in flight.
module rd_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic [1:0] i_valid,
    output logic [1:0] o_valid
);

    logic [1:0] r_sr [DEPTH];

    // Shift the valid flags one stage per cycle; clear flushes all stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= 2'b00;
            end
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= 2'b00;
            end
        end else begin
            r_sr[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_valid = r_sr[DEPTH-1];

endmodule

// File: rtl/fmap_read_ctrl.sv
// fmap_read_ctrl: sequences RAM reads for one convolution job -- an optional
// weight preload burst, a short gap so the WorI switch reaches downstream
// before pixels do, then a row-major sweep of an SxS feature map.
// Optional feature: define FMAP_READ_CTRL_ABORT_EN to add an abort input
// that cancels a running job without a done pulse.
module fmap_read_ctrl
    import fmap_rd_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            mode_in,
    input  logic [ADDR_WIDTH-1:0] weight_base,
    input  logic [5:0]            weight_count,
    input  logic [ADDR_WIDTH-1:0] fmap_base,
    input  logic                  stall,
`ifdef FMAP_READ_CTRL_ABORT_EN
    input  logic                  abort,
`endif
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  rd_en,
    output logic                  WorI,
    output logic [2:0]            mode,
    output logic                  data_valid,
    output logic                  weight_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LATENCY - 1);

    fmap_state_e           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_fmap_base;
    logic [2:0]            r_mode;
    logic [5:0]            r_size;
    logic [5:0]            r_wcnt;
    logic [5:0]            r_wk;
    logic [5:0]            r_row;
    logic [5:0]            r_col;
    logic [LW-1:0]         r_lat;
    logic                  r_rd_act;
    logic                  r_wori;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_issue;
    logic                  w_pipe_clr;
    logic [1:0]            w_pipe_in;
    logic [1:0]            w_pipe_out;

    // A read goes out only in an issuing phase and never while stalled; the
    // stall gate is combinational so back-pressure takes effect the same cycle.
    assign w_issue = r_rd_act & ~stall;

`ifdef FMAP_READ_CTRL_ABORT_EN
    assign w_pipe_clr = abort & (r_state != ST_IDLE);
`else
    assign w_pipe_clr = 1'b0;
`endif

    // Controller state machine; all status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= {ADDR_WIDTH{1'b0}};
            r_fmap_base <= {ADDR_WIDTH{1'b0}};
            r_mode      <= 3'd0;
            r_size      <= 6'd0;
            r_wcnt      <= 6'd0;
            r_wk        <= 6'd0;
            r_row       <= 6'd0;
            r_col       <= 6'd0;
            r_lat       <= {LW{1'b0}};
            r_rd_act    <= 1'b0;
            r_wori      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end
`ifdef FMAP_READ_CTRL_ABORT_EN
        else if (abort && (r_state != ST_IDLE)) begin
            r_state  <= ST_IDLE;
            r_rd_act <= 1'b0;
            r_wori   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end
`endif
        else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode_in > MAX_MODE) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mode      <= mode_in;
                            r_size      <= mode_to_size(mode_in);
                            r_fmap_base <= fmap_base;
                            r_wcnt      <= weight_count;
                            r_wk        <= 6'd0;
                            r_row       <= 6'd0;
                            r_col       <= 6'd0;
                            r_busy      <= 1'b1;
                            r_rd_act    <= 1'b1;
                            if (weight_count == 6'd0) begin
                                r_state <= ST_STREAM;
                                r_addr  <= fmap_base;
                                r_wori  <= 1'b0;
                            end else begin
                                r_state <= ST_LOAD_W;
                                r_addr  <= weight_base;
                                r_wori  <= 1'b1;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD_W: begin
                    if (w_issue) begin
                        if (r_wk == (r_wcnt - 6'd1)) begin
                            // Last weight out: park on the pixel base for the gap.
                            r_state  <= ST_GAP;
                            r_rd_act <= 1'b0;
                            r_wori   <= 1'b0;
                            r_addr   <= r_fmap_base;
                            r_lat    <= {LW{1'b0}};
                        end else begin
                            r_wk   <= r_wk + 6'd1;
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                    end else begin
                        r_state <= ST_LOAD_W;
                    end
                end
                ST_GAP: begin
                    if (r_lat == LAT_LAST) begin
                        r_state  <= ST_STREAM;
                        r_rd_act <= 1'b1;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                ST_STREAM: begin
                    if (w_issue) begin
                        // Row-major pixels are contiguous, so the address just increments.
                        if (r_col == (r_size - 6'd1)) begin
                            r_col <= 6'd0;
                            if (r_row == (r_size - 6'd1)) begin
                                r_state  <= ST_FLUSH;
                                r_rd_act <= 1'b0;
                                r_lat    <= {LW{1'b0}};
                            end else begin
                                r_row  <= r_row + 6'd1;
                                r_addr <= r_addr + ADDR_WIDTH'(1);
                            end
                        end else begin
                            r_col  <= r_col + 6'd1;
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_FLUSH: begin
                    // Wait for the last pixel to leave the RAM before signalling done.
                    if (r_lat == LAT_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_rd_act <= 1'b0;
                    r_wori   <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign read_addr = r_addr;
    assign rd_en     = w_issue;
    assign WorI      = r_wori;
    assign mode      = r_mode;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    assign w_pipe_in = {rd_en & WorI, rd_en & ~WorI};

    rd_valid_pipe #(
        .DEPTH (RAM_LATENCY)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_pipe_clr),
        .i_valid (w_pipe_in),
        .o_valid (w_pipe_out)
    );

    assign weight_valid = w_pipe_out[1];
    assign data_valid   = w_pipe_out[0];

endmodule

// File: tb/tb_fmap_read_ctrl.sv
// Scoreboard bench for fmap_read_ctrl: jobs push their expected read stream
// into a queue, a negedge monitor pops and compares every issued read.
module tb_fmap_read_ctrl;

    localparam int L  = 2;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    mode_in = 3'd0;
    logic [AW-1:0] weight_base = '0;
    logic [5:0]    weight_count = 6'd0;
    logic [AW-1:0] fmap_base = '0;
    logic          stall = 1'b0;

    logic [AW-1:0] read_addr;
    logic          rd_en, WorI, data_valid, weight_valid, busy, done, err;
    logic [2:0]    mode;

    fmap_read_ctrl #(.ADDR_WIDTH(AW), .RAM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
        .weight_base(weight_base), .weight_count(weight_count),
        .fmap_base(fmap_base), .stall(stall), .read_addr(read_addr),
        .rd_en(rd_en), .WorI(WorI), .mode(mode), .data_valid(data_valid),
        .weight_valid(weight_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
    } iss_t;

    iss_t       exp_q[$];
    iss_t       mon_e;
    logic [1:0] hist[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wv_cnt = 0, dv_cnt = 0;
    int last_issue_cyc = 0, last_w_cyc = -1, first_d_cyc = -1;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic int size_of(input logic [2:0] m);
        case (m)
            3'd0: return 32;
            3'd1: return 28;
            3'd2: return 14;
            3'd3: return 10;
            default: return 5;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each read and checks valid alignment.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                last_issue_cyc = cyc;
                if (WorI) last_w_cyc = cyc;
                else if (last_w_cyc >= 0 && first_d_cyc < 0) first_d_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got addr %0h with nothing expected", read_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_addr", read_addr, mon_e.a);
                    chk("issue_wori", WorI, mon_e.w);
                end
            end
            if (stall) chk("stall_rd_en", rd_en, 0);
            if (weight_valid) wv_cnt++;
            if (data_valid) dv_cnt++;
            hist.push_front({rd_en & WorI, rd_en & ~WorI});
            if (hist.size() > L) begin
                chk("valid_align", {weight_valid, data_valid}, hist[L]);
                void'(hist.pop_back());
            end
        end
    end

    task automatic push_model(input logic [2:0] m, input logic [5:0] wc,
                              input logic [AW-1:0] wb, input logic [AW-1:0] fb);
        iss_t e;
        int s;
        s = size_of(m);
        for (int k = 0; k < int'(wc); k++) begin
            e.w = 1'b1;
            e.a = AW'(int'(wb) + k);
            exp_q.push_back(e);
        end
        for (int r = 0; r < s; r++) begin
            for (int c = 0; c < s; c++) begin
                e.w = 1'b0;
                e.a = AW'(int'(fb) + r * s + c);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_job(input logic [2:0] m, input logic [5:0] wc,
                           input logic [AW-1:0] wb, input logic [AW-1:0] fb,
                           input int stall_pct, input int stall_addr,
                           input bit poke, input bit chk_gap);
        int s, budget, stall_left;
        bit got_done, stall_used;
        s = size_of(m);
        push_model(m, wc, wb, fb);
        wv_cnt = 0; dv_cnt = 0; last_w_cyc = -1; first_d_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; mode_in = m; weight_count = wc; weight_base = wb; fmap_base = fb;
        @(posedge clk); #1;
        start = 1'b0;
        mode_in = 3'($urandom_range(7, 0));
        weight_count = 6'($urandom);
        weight_base = AW'($urandom);
        fmap_base = AW'($urandom);
        chk("busy_after_start", busy, 1);
        chk("mode_latched", mode, m);
        budget = 4 * (int'(wc) + s * s) + 50;
        got_done = 1'b0; stall_left = 0; stall_used = 1'b0;
        for (int it = 0; it < budget; it++) begin
            start = 1'b0;
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else if (stall_addr >= 0 && !stall_used && busy && !WorI &&
                         int'(read_addr) == stall_addr) begin
                stall = 1'b1;
                stall_left = 2;
                stall_used = 1'b1;
            end else begin
                stall = ($urandom_range(99, 0) < stall_pct);
            end
            if (poke && it == 5) begin
                start = 1'b1;
                mode_in = 3'd2;
            end
            @(negedge clk);
            if (poke && it == 6) begin
                chk("busy_start_no_err", err, 0);
                chk("busy_start_mode_kept", mode, m);
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: no done within %0d cycles, mode %0d", budget, m);
        end else begin
            chk("done_busy_low", busy, 0);
            chk("queue_drained", exp_q.size(), 0);
            chk("wv_count", wv_cnt, wc);
            chk("dv_count", dv_cnt, s * s);
            chk("done_latency", cyc - last_issue_cyc, L + 1);
            if (chk_gap) chk("gap_len", first_d_cyc - last_w_cyc, L + 1);
            if (stall_addr >= 0) chk("stall_hit", stall_used, 1);
            @(negedge clk);
            chk("done_single", done, 0);
            chk("idle_busy", busy, 0);
        end
        exp_q.delete();
    endtask

    initial begin
        #12;
        chk("rst_addr", read_addr, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wori", WorI, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Weight preload then a 5x5 map, no stall.
        run_job(3'd4, 6'd25, 11'h700, 11'h000, 0, -1, 1'b0, 1'b1);
        // No weights: straight into a 32x32 stream.
        run_job(3'd0, 6'd0, 11'h000, 11'h000, 0, -1, 1'b0, 1'b0);
        // Directed three-cycle stall when address 37 is next.
        run_job(3'd3, 6'd0, 11'h000, 11'h000, 0, 37, 1'b0, 1'b0);
        // Address wrap on both weights and pixels.
        run_job(3'd4, 6'd3, 11'h7FE, 11'h7F0, 0, -1, 1'b0, 1'b1);

        // Illegal mode: single err pulse, stays idle.
        @(posedge clk); #1;
        start = 1'b1; mode_in = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_mode_kept", mode, 3'd4);
        @(posedge clk); #1;
        chk("err_single", err, 0);
        chk("err_still_idle", busy, 0);

        // Start while busy is ignored.
        run_job(3'd1, 6'd10, 11'($urandom), 11'($urandom), 0, -1, 1'b1, 1'b0);

        // Randomised jobs with random back-pressure.
        for (int j = 0; j < 6; j++) begin
            run_job(3'($urandom_range(4, 1)), 6'($urandom_range(63, 0)),
                    11'($urandom), 11'($urandom), 25, -1, 1'b0, 1'b0);
        end

        // Reset in the middle of a stream.
        push_model(3'd2, 6'd0, 11'h000, 11'h123);
        @(posedge clk); #1;
        start = 1'b1; mode_in = 3'd2; weight_count = 6'd0; fmap_base = 11'h123;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", read_addr, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_wori", WorI, 0);
        chk("mid_rst_valid", {weight_valid, data_valid}, 0);
        chk("mid_rst_done", done, 0);
        exp_q.delete();
        hist.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) chk("no_done_after_rst", {done, busy}, 0);
        end
        chk("post_rst_idle", busy, 0);

        // Recovery job after reset.
        run_job(3'd4, 6'd5, 11'($urandom), 11'($urandom), 10, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
